sfp_frame_link: RTL

- Sits between the AXI-Lite control block and the Aurora/GT user interface, directly downstream of the control block's frame output and upstream of its frame input.
- TX path: serializes the 128-bit SFP command frame into 32-bit AXI4-Stream words and appends an XOR checksum.
- RX path: reassembles received words into a frame, checks it, and returns valid frames with a one-cycle end flag.
- Provides the transmit-ready level the control block waits on before leaving its DONE states.

---
 rtl/sfp_link_pkg.sv | 31 +++
 rtl/sfp_frame_rx.sv | 110 +++++++++++
 rtl/sfp_frame_link.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sfp_link_pkg.sv
// Shared constants, state encodings and helpers for the SFP frame link.
// Frame layout: FRAME_WORDS data words, MSB word first, then one XOR checksum word.
package sfp_link_pkg;

  localparam int C_FRAME_BIT_DEF = 128;
  localparam int C_WORD_BIT_DEF  = 32;
  localparam int FRAME_WORDS     = C_FRAME_BIT_DEF / C_WORD_BIT_DEF;
  localparam int CSUM_WORDS      = 1;

  // Command and slave-id fields, as {msb, lsb} bit offsets within the frame.
  localparam int CMD_MSB = 127;
  localparam int CMD_LSB = 112;
  localparam int SID_MSB = 111;
  localparam int SID_LSB = 96;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_DATA = 2'd1,
    TX_CSUM = 2'd2
  } tx_state_e;

  typedef enum logic [0:0] {
    RX_COLLECT = 1'b0,
    RX_DISCARD = 1'b1
  } rx_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/sfp_frame_rx.sv
// RX half of the SFP link: reassembles words into a frame, verifies the XOR
// checksum, publishes good frames with a one-cycle end flag, counts bad ones.
module sfp_frame_rx
  import sfp_link_pkg::*;
#(
  parameter int C_DATA_FRAME_BIT = C_FRAME_BIT_DEF,
  parameter int C_WORD_BIT       = C_WORD_BIT_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [C_WORD_BIT-1:0]       i_tdata,
  input  logic                        i_tvalid,
  input  logic                        i_tlast,
  output logic [C_DATA_FRAME_BIT-1:0] o_frame,
  output logic                        o_end_flag,
  output logic [15:0]                 o_err_cnt
);

  localparam int LP_WORDS = C_DATA_FRAME_BIT / C_WORD_BIT;
  localparam int LP_CNT_W = $clog2(LP_WORDS + CSUM_WORDS + 1);
  localparam logic [LP_CNT_W-1:0] LP_LAST_BEAT = LP_CNT_W'(LP_WORDS + CSUM_WORDS);

  rx_state_e                   r_state,  w_state_nxt;
  logic [C_DATA_FRAME_BIT-1:0] r_buf,    w_buf_nxt;
  logic [C_DATA_FRAME_BIT-1:0] r_frame,  w_frame_nxt;
  logic [C_WORD_BIT-1:0]       r_xor,    w_xor_nxt;
  logic [LP_CNT_W-1:0]         r_cnt,    w_cnt_nxt;
  logic                        r_end,    w_end_nxt;
  logic [15:0]                 r_err,    w_err_nxt;
  logic [LP_CNT_W-1:0]         w_cnt_inc;

  assign w_cnt_inc = r_cnt + LP_CNT_W'(1);

  // Beat handling: the buffer keeps the last LP_WORDS beats, so on the checksum
  // beat it holds exactly the data words.
  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_frame_nxt = r_frame;
    w_xor_nxt   = r_xor;
    w_cnt_nxt   = r_cnt;
    w_end_nxt   = 1'b0;
    w_err_nxt   = r_err;
    if (i_tvalid) begin
      case (r_state)
        RX_COLLECT: begin
          w_buf_nxt = {r_buf[C_DATA_FRAME_BIT-C_WORD_BIT-1:0], i_tdata};
          if (i_tlast) begin
            w_cnt_nxt = '0;
            w_xor_nxt = '0;
            if ((w_cnt_inc == LP_LAST_BEAT) && (r_xor == i_tdata)) begin
              w_frame_nxt = r_buf;
              w_end_nxt   = 1'b1;
            end else begin
              w_err_nxt = sat_inc16(r_err);
            end
          end else if (w_cnt_inc == LP_LAST_BEAT) begin
            w_err_nxt   = sat_inc16(r_err);
            w_state_nxt = RX_DISCARD;
            w_cnt_nxt   = '0;
            w_xor_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            w_xor_nxt = r_xor ^ i_tdata;
          end
        end
        RX_DISCARD: begin
          if (i_tlast) begin
            w_state_nxt = RX_COLLECT;
          end else begin
            w_state_nxt = RX_DISCARD;
          end
        end
        default: begin
          w_state_nxt = RX_COLLECT;
          w_cnt_nxt   = '0;
          w_xor_nxt   = '0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= RX_COLLECT;
      r_buf   <= '0;
      r_frame <= '0;
      r_xor   <= '0;
      r_cnt   <= '0;
      r_end   <= 1'b0;
      r_err   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_frame <= w_frame_nxt;
      r_xor   <= w_xor_nxt;
      r_cnt   <= w_cnt_nxt;
      r_end   <= w_end_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_frame    = r_frame;
  assign o_end_flag = r_end;
  assign o_err_cnt  = r_err;

endmodule

// File: rtl/sfp_frame_link.sv
// SFP frame link top: TX serializer FSM with XOR checksum word, plus the RX
// reassembly sub-module. All AXI-Stream outputs are registered.
module sfp_frame_link
  import sfp_link_pkg::*;
#(
  parameter int C_DATA_FRAME_BIT = C_FRAME_BIT_DEF,
  parameter int C_WORD_BIT       = C_WORD_BIT_DEF
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic                        i_sfp_start_flag,
  input  logic [C_DATA_FRAME_BIT-1:0] i_tx_frame,
  output logic                        o_tx_en,
  input  logic                        i_channel_up,
  output logic [C_WORD_BIT-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  input  logic [C_WORD_BIT-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic [C_DATA_FRAME_BIT-1:0] o_rx_frame,
  output logic                        o_sfp_end_flag,
  output logic [15:0]                 o_tx_drop_cnt,
  output logic [15:0]                 o_rx_err_cnt
);

  localparam int LP_WORDS = C_DATA_FRAME_BIT / C_WORD_BIT;
  localparam int LP_IDX_W = (LP_WORDS > 1) ? $clog2(LP_WORDS) : 1;
  localparam logic [LP_IDX_W-1:0] LP_IDX_LAST = LP_IDX_W'(LP_WORDS - 1);

  function automatic logic [C_WORD_BIT-1:0] f_csum(input logic [C_DATA_FRAME_BIT-1:0] frame);
    logic [C_WORD_BIT-1:0] acc;
    acc = '0;
    for (int i = 0; i < LP_WORDS; i++) begin
      acc = acc ^ frame[i*C_WORD_BIT +: C_WORD_BIT];
    end
    return acc;
  endfunction

  tx_state_e                   r_state,  w_state_nxt;
  logic [C_DATA_FRAME_BIT-1:0] r_shift,  w_shift_nxt;
  logic [C_WORD_BIT-1:0]       r_csum,   w_csum_nxt;
  logic [LP_IDX_W-1:0]         r_idx,    w_idx_nxt;
  logic [C_WORD_BIT-1:0]       r_tdata,  w_tdata_nxt;
  logic                        r_tvalid, w_tvalid_nxt;
  logic                        r_tlast,  w_tlast_nxt;
  logic                        r_tx_en,  w_tx_en_nxt;
  logic [15:0]                 r_drop,   w_drop_nxt;
  logic                        w_hs;
  logic [C_DATA_FRAME_BIT-1:0] w_shifted;

  assign w_hs      = r_tvalid & m_axis_tready;
  assign w_shifted = r_shift << C_WORD_BIT;

  // TX next-state: the frame is held in a shift register whose top word is the
  // next one to present, so tdata only changes on a handshake.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_csum_nxt   = r_csum;
    w_idx_nxt    = r_idx;
    w_tdata_nxt  = r_tdata;
    w_tvalid_nxt = r_tvalid;
    w_tlast_nxt  = r_tlast;
    w_tx_en_nxt  = r_tx_en;
    case (r_state)
      TX_IDLE: begin
        if (i_sfp_start_flag && i_channel_up) begin
          w_state_nxt  = TX_DATA;
          w_shift_nxt  = i_tx_frame;
          w_csum_nxt   = f_csum(i_tx_frame);
          w_idx_nxt    = '0;
          w_tdata_nxt  = i_tx_frame[C_DATA_FRAME_BIT-1 -: C_WORD_BIT];
          w_tvalid_nxt = 1'b1;
          w_tlast_nxt  = 1'b0;
          w_tx_en_nxt  = 1'b0;
        end else begin
          w_state_nxt = TX_IDLE;
        end
      end
      TX_DATA: begin
        if (w_hs && (r_idx == LP_IDX_LAST)) begin
          w_state_nxt = TX_CSUM;
          w_tdata_nxt = r_csum;
          w_tlast_nxt = 1'b1;
        end else if (w_hs) begin
          w_shift_nxt = w_shifted;
          w_tdata_nxt = w_shifted[C_DATA_FRAME_BIT-1 -: C_WORD_BIT];
          w_idx_nxt   = r_idx + LP_IDX_W'(1);
        end else begin
          w_state_nxt = TX_DATA;
        end
      end
      TX_CSUM: begin
        if (w_hs) begin
          w_state_nxt  = TX_IDLE;
          w_tdata_nxt  = '0;
          w_tvalid_nxt = 1'b0;
          w_tlast_nxt  = 1'b0;
          w_tx_en_nxt  = 1'b1;
        end else begin
          w_state_nxt = TX_CSUM;
        end
      end
      default: begin
        w_state_nxt  = TX_IDLE;
        w_tdata_nxt  = '0;
        w_tvalid_nxt = 1'b0;
        w_tlast_nxt  = 1'b0;
        w_tx_en_nxt  = 1'b1;
      end
    endcase
  end

  // Starts that cannot be honoured: link down while idle, or a frame in flight.
  always_comb begin
    if (i_sfp_start_flag && ((r_state != TX_IDLE) || !i_channel_up)) begin
      w_drop_nxt = sat_inc16(r_drop);
    end else begin
      w_drop_nxt = r_drop;
    end
  end

  // TX state and output registers.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_state  <= TX_IDLE;
      r_shift  <= '0;
      r_csum   <= '0;
      r_idx    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tx_en  <= 1'b1;
      r_drop   <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_csum   <= w_csum_nxt;
      r_idx    <= w_idx_nxt;
      r_tdata  <= w_tdata_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_tlast  <= w_tlast_nxt;
      r_tx_en  <= w_tx_en_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  assign o_tx_en       = r_tx_en;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign o_tx_drop_cnt = r_drop;

  sfp_frame_rx #(
    .C_DATA_FRAME_BIT(C_DATA_FRAME_BIT),
    .C_WORD_BIT      (C_WORD_BIT)
  ) u_rx (
    .i_clk     (S_AXI_ACLK),
    .i_rst_n   (S_AXI_ARESETN),
    .i_tdata   (s_axis_tdata),
    .i_tvalid  (s_axis_tvalid),
    .i_tlast   (s_axis_tlast),
    .o_frame   (o_rx_frame),
    .o_end_flag(o_sfp_end_flag),
    .o_err_cnt (o_rx_err_cnt)
  );

endmodule
